// File: rtl/etc_pkg.sv
// Shared definitions for the tensor-core tile accumulator.
//   - Opcode constants carried on in_op (MAC = add-reduce, anything else = min-plus).
//   - Tile typedef at the default element width (4x4 lanes of 16 bits).
//   - Accumulator FSM state enum.
package etc_pkg;

  localparam logic [1:0] ETC_OP_MAC  = 2'd0;
  localparam logic [1:0] ETC_OP_APSP = 2'd1;

  localparam int unsigned EtcDefaultW = 16;

  // Default-width tile; the RTL itself uses the W-parameterised form of the same shape.
  typedef logic [3:0][3:0][EtcDefaultW-1:0] etc_tile_t;

  typedef enum logic [1:0] {
    StEmpty,  // no partial group
    StAcc,    // partial group held in the accumulator
    StFull    // finished group parked in the accumulator, waiting for the output slot
  } etc_state_e;

endpackage

// File: rtl/etc_combine.sv
// Element-wise combine of two 4x4 tiles.
//   acc_i     : running accumulator tile
//   tile_i    : incoming partial-product tile
//   min_sel_i : 1 = unsigned min (min-plus), 0 = add (MAC)
//   res_o     : combined tile
// Build option: ETC_ACCUM_SAT_EN makes MAC addition saturate at 2^W-1 instead of wrapping.
module etc_combine #(
  parameter int unsigned W = 16
) (
  input  logic [3:0][3:0][W-1:0] acc_i,
  input  logic [3:0][3:0][W-1:0] tile_i,
  input  logic                   min_sel_i,
  output logic [3:0][3:0][W-1:0] res_o
);

  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      logic [W-1:0] min_v;
      logic [W-1:0] add_v;

      assign min_v = (acc_i[r][c] < tile_i[r][c]) ? acc_i[r][c] : tile_i[r][c];

`ifdef ETC_ACCUM_SAT_EN
      logic [W:0] sum_v;
      assign sum_v = {1'b0, acc_i[r][c]} + {1'b0, tile_i[r][c]};
      // Carry out means the true sum exceeds the lane range: clamp to all ones.
      assign add_v = sum_v[W] ? {W{1'b1}} : sum_v[W-1:0];
`else
      assign add_v = acc_i[r][c] + tile_i[r][c];
`endif

      assign res_o[r][c] = min_sel_i ? min_v : add_v;
    end
  end

endmodule

// File: rtl/etc_tile_accum.sv
// Reduction accumulator for 4x4 tensor-core partial-result tiles.
// Tiles of a group are folded element-wise (add for MAC, unsigned min for min-plus);
// the op is taken from the group's first tile. A finished group goes to a one-entry
// output buffer, or waits in the accumulator (FULL) while that buffer is occupied.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : input tile handshake
//   in_tile, in_op       : partial tile and opcode (op used on first tile only)
//   in_last              : final tile of the group
//   out_valid/out_ready  : output handshake
//   out_tile, out_count  : reduced tile and saturating tile count
// Build option: ETC_ACCUM_SAT_EN (saturating MAC addition, see etc_combine).
module etc_tile_accum
  import etc_pkg::*;
#(
  parameter int unsigned W  = 16,
  parameter int unsigned CW = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0][3:0][W-1:0] in_tile,
  input  logic [1:0]             in_op,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [3:0][3:0][W-1:0] out_tile,
  output logic [CW-1:0]          out_count
);

  etc_state_e state_q, state_d;

  logic [3:0][3:0][W-1:0] acc_q, acc_d;
  logic [3:0][3:0][W-1:0] comb_res, merged;
  logic [1:0]             op_q, op_d;
  logic [CW-1:0]          cnt_q, cnt_d, cnt_next;

  logic                   out_valid_q, out_valid_d;
  logic [3:0][3:0][W-1:0] out_tile_q, out_tile_d;
  logic [CW-1:0]          out_count_q, out_count_d;

  logic accept, is_first, buf_free;

  etc_combine #(
    .W (W)
  ) u_combine (
    .acc_i     (acc_q),
    .tile_i    (in_tile),
    .min_sel_i (op_q != ETC_OP_MAC),
    .res_o     (comb_res)
  );

  assign in_ready = (state_q != StFull);
  assign accept   = in_valid && in_ready;
  assign is_first = (state_q == StEmpty);
  // Output slot can take a new entry if empty or being drained on this edge.
  assign buf_free = !out_valid_q || out_ready;

  always_comb begin
    merged   = is_first ? in_tile : comb_res;
    cnt_next = is_first ? CW'(1) : ((&cnt_q) ? cnt_q : cnt_q + CW'(1));
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q && !out_ready;
    out_tile_d  = out_tile_q;
    out_count_d = out_count_q;

    unique case (state_q)
      StEmpty, StAcc: begin
        if (accept) begin
          if (is_first) begin
            op_d = in_op;
          end
          if (!in_last) begin
            acc_d   = merged;
            cnt_d   = cnt_next;
            state_d = StAcc;
          end else if (buf_free) begin
            out_tile_d  = merged;
            out_count_d = cnt_next;
            out_valid_d = 1'b1;
            state_d     = StEmpty;
          end else begin
            acc_d   = merged;
            cnt_d   = cnt_next;
            state_d = StFull;
          end
        end
      end
      StFull: begin
        if (buf_free) begin
          out_tile_d  = acc_q;
          out_count_d = cnt_q;
          out_valid_d = 1'b1;
          state_d     = StEmpty;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StEmpty;
      acc_q       <= '0;
      op_q        <= ETC_OP_MAC;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_tile_q  <= '0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_tile_q  <= out_tile_d;
      out_count_q <= out_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_tile  = out_tile_q;
  assign out_count = out_count_q;

endmodule

// File: tb/tb_etc_tile_accum.sv
module tb_etc_tile_accum;
  import etc_pkg::*;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  etc_tile_t       in_tile;
  logic [1:0]      in_op;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  etc_tile_t       out_tile;
  logic [7:0]      out_count;

  int checks = 0;
  int errors = 0;

  // Reference model state: tiles of the open group and the group's op.
  etc_tile_t  grp[$];
  logic [1:0] grp_op;

  etc_tile_accum #(
    .W  (16),
    .CW (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_tile   (in_tile),
    .in_op     (in_op),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_tile  (out_tile),
    .out_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic etc_tile_t fill(input logic [15:0] v);
    etc_tile_t t;
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) t[r][c] = v;
    return t;
  endfunction

  function automatic etc_tile_t rand_tile(input int unsigned maxv);
    etc_tile_t t;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) t[r][c] = 16'($urandom_range(0, maxv));
    return t;
  endfunction

  // Reduction of the whole group: plain sum (wrapped or clamped) or plain minimum.
  function automatic etc_tile_t model_result();
    etc_tile_t res;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (grp_op == ETC_OP_MAC) begin
          int unsigned total = 0;
          foreach (grp[i]) total += int'(grp[i][r][c]);
`ifdef ETC_ACCUM_SAT_EN
          res[r][c] = (total > 65535) ? 16'hFFFF : 16'(total);
`else
          res[r][c] = 16'(total % 65536);
`endif
        end else begin
          int unsigned m = 65535;
          foreach (grp[i]) if (int'(grp[i][r][c]) < m) m = int'(grp[i][r][c]);
          res[r][c] = 16'(m);
        end
      end
    end
    return res;
  endfunction

  function automatic logic [7:0] model_count();
    return (grp.size() > 255) ? 8'd255 : 8'(grp.size());
  endfunction

  task automatic send(input etc_tile_t t, input logic [1:0] op, input logic last);
    in_valid = 1'b1;
    in_tile  = t;
    in_op    = op;
    in_last  = last;
    if (grp.size() == 0) grp_op = op;
    grp.push_back(t);
    tick();
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    in_tile   = '0;
    in_op     = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    grp.delete();
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    checks++;
    if (out_tile !== '0 || out_count !== 8'd0) begin
      errors++; $display("FAIL reset_outputs got tile %h count %0d want 0", out_tile, out_count);
    end
  endtask

  task automatic test_mac();
    etc_tile_t exp_t;
    logic [7:0] exp_c;
    logic [15:0] vals[3] = '{16'd2, 16'd3, 16'd5};
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) send(fill(vals[k]), ETC_OP_MAC, k == 2);
    in_valid = 1'b0;
    exp_t = model_result();
    exp_c = model_count();
    grp.delete();
    checks++;
    if (out_valid !== 1'b1 || out_tile !== exp_t || out_tile[2][1] !== 16'd10) begin
      errors++; $display("FAIL mac_sum got v=%b tile %h want v=1 tile %h", out_valid, out_tile, exp_t);
    end
    checks++;
    if (out_count !== exp_c) begin
      errors++; $display("FAIL mac_count got %0d want %0d", out_count, exp_c);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL mac_valid_drop got %b want 0", out_valid);
    end
  endtask

  task automatic test_apsp();
    etc_tile_t t;
    etc_tile_t exp_t;
    logic [15:0] v00[3] = '{16'd9, 16'd4, 16'd7};
    logic [1:0]  ops[3] = '{ETC_OP_APSP, ETC_OP_MAC, ETC_OP_APSP};
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      t = rand_tile(65535);
      t[0][0] = v00[k];
      send(t, ops[k], k == 2);
    end
    in_valid = 1'b0;
    exp_t = model_result();
    grp.delete();
    checks++;
    if (out_valid !== 1'b1 || out_tile[0][0] !== 16'd4) begin
      errors++; $display("FAIL apsp_e00 got v=%b %0d want v=1 4", out_valid, out_tile[0][0]);
    end
    checks++;
    if (out_tile !== exp_t || out_count !== 8'd3) begin
      errors++; $display("FAIL apsp_tile got %h/%0d want %h/3", out_tile, out_count, exp_t);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    send(fill(16'd1), ETC_OP_MAC, 1'b1);
    grp.delete();
    checks++;
    if (out_valid !== 1'b1 || out_tile !== fill(16'd1) || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_first got v=%b e=%0d rdy=%b want 1 1 1",
                         out_valid, out_tile[0][0], in_ready);
    end
    send(fill(16'd2), ETC_OP_MAC, 1'b1);
    grp.delete();
    checks++;
    if (in_ready !== 1'b0 || out_tile !== fill(16'd1) || out_count !== 8'd1) begin
      errors++; $display("FAIL bp_full got rdy=%b e=%0d cnt=%0d want 0 1 1",
                         in_ready, out_tile[0][0], out_count);
    end
    // A tile offered while FULL must be refused.
    in_tile = fill(16'd9);
    in_last = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_tile !== fill(16'd1) || in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_stall got v=%b e=%0d rdy=%b want 1 1 0",
                         out_valid, out_tile[0][0], in_ready);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_tile !== fill(16'd2) || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_second got v=%b e=%0d rdy=%b want 1 2 1",
                         out_valid, out_tile[0][0], in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_empty got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    etc_tile_t t;
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      t = rand_tile(65535);
      send(t, 2'($urandom_range(0, 3)), 1'b1);
      grp.delete();
      checks++;
      if (out_valid !== 1'b1 || out_tile !== t || out_count !== 8'd1 || in_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_%0d got v=%b tile %h cnt=%0d rdy=%b want tile %h",
                           k, out_valid, out_tile, out_count, in_ready, t);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_wrap();
    etc_tile_t exp_t;
`ifdef ETC_ACCUM_SAT_EN
    exp_t = fill(16'hFFFF);
`else
    exp_t = fill(16'h0010);
`endif
    do_reset();
    out_ready = 1'b1;
    send(fill(16'hFFF0), ETC_OP_MAC, 1'b0);
    send(fill(16'h0020), ETC_OP_MAC, 1'b1);
    in_valid = 1'b0;
    grp.delete();
    checks++;
    if (out_valid !== 1'b1 || out_tile !== exp_t) begin
      errors++; $display("FAIL wrap got v=%b e=%h want 1 %h", out_valid, out_tile[0][0], exp_t[0][0]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    send(fill(16'd5), ETC_OP_MAC, 1'b1);
    send(rand_tile(100), ETC_OP_MAC, 1'b0);
    send(rand_tile(100), ETC_OP_MAC, 1'b0);
    in_valid = 1'b0;
    grp.delete();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_tile !== '0 || out_count !== 8'd0) begin
      errors++; $display("FAIL rst_mid_clear got v=%b e=%0d cnt=%0d want 0 0 0",
                         out_valid, out_tile[0][0], out_count);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_idle got rdy=%b v=%b want 1 0", in_ready, out_valid);
    end
    out_ready = 1'b1;
    send(fill(16'd7), ETC_OP_MAC, 1'b1);
    in_valid = 1'b0;
    grp.delete();
    checks++;
    if (out_valid !== 1'b1 || out_tile !== fill(16'd7) || out_count !== 8'd1) begin
      errors++; $display("FAIL rst_mid_group got v=%b e=%0d cnt=%0d want 1 7 1",
                         out_valid, out_tile[0][0], out_count);
    end
  endtask

  task automatic test_count_sat();
    etc_tile_t exp_t;
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 300; k++) send(rand_tile(65535), ETC_OP_MAC, k == 299);
    in_valid = 1'b0;
    exp_t = model_result();
    checks++;
    if (out_valid !== 1'b1 || out_count !== 8'd255 || out_tile !== exp_t) begin
      errors++; $display("FAIL count_sat got v=%b cnt=%0d e=%h want 1 255 %h",
                         out_valid, out_count, out_tile[0][0], exp_t[0][0]);
    end
    grp.delete();
  endtask

  task automatic test_random();
    etc_tile_t  exp_t[$];
    logic [7:0] exp_c[$];
    etc_tile_t  t, et, hold_t;
    logic [7:0] ec, hold_c;
    logic [1:0] op;
    logic       lst, acc, pop, hold;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      t   = rand_tile(($urandom_range(0, 1) == 0) ? 255 : 65535);
      op  = 2'($urandom_range(0, 3));
      lst = ($urandom_range(0, 2) == 0);
      if (cyc < 370) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        // Close any open group and drain everything.
        lst       = 1'b1;
        in_valid  = (grp.size() != 0);
        out_ready = 1'b1;
      end
      in_tile = t;
      in_op   = op;
      in_last = lst;
      #1;
      acc    = in_valid && in_ready;
      pop    = out_valid && out_ready;
      hold   = out_valid && !out_ready;
      hold_t = out_tile;
      hold_c = out_count;
      if (pop) begin
        checks++;
        if (exp_t.size() == 0) begin
          errors++; $display("FAIL rnd_pop cyc %0d got unexpected output want none", cyc);
        end else begin
          et = exp_t.pop_front();
          ec = exp_c.pop_front();
          if (out_tile !== et || out_count !== ec) begin
            errors++; $display("FAIL rnd_out cyc %0d got %h/%0d want %h/%0d",
                               cyc, out_tile, out_count, et, ec);
          end
        end
      end
      tick();
      if (acc) begin
        if (grp.size() == 0) grp_op = op;
        grp.push_back(t);
        if (lst) begin
          exp_t.push_back(model_result());
          exp_c.push_back(model_count());
          grp.delete();
        end
      end
      if (hold) begin
        checks++;
        if (out_valid !== 1'b1 || out_tile !== hold_t || out_count !== hold_c) begin
          errors++; $display("FAIL rnd_stable cyc %0d got %b %h/%0d want 1 %h/%0d",
                             cyc, out_valid, out_tile, out_count, hold_t, hold_c);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (exp_t.size() != 0 || grp.size() != 0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rnd_drain got pending=%0d open=%0d v=%b want 0 0 0",
                         exp_t.size(), grp.size(), out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_mac();
    test_apsp();
    test_backpressure();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    test_count_sat();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
